// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle multiply/divide unit for the EX stage. A one-cycle start
//   captures the operands and computes the full 64-bit result into pending
//   registers. The unit then holds busy for MULT_CYCLES or DIV_CYCLES cycles
//   and commits the result to the architectural HI/LO registers. MTHI/MTLO
//   write HI/LO directly at the next edge and do not assert busy.
//
//   Optional build macro: MULDIV_ABORT_EN adds an abort input. Abort flushes
//   an in-flight operation without committing it, and suppresses a
//   same-cycle start while idle.
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   start    in   EX instruction is MULT/MULTU/DIV/DIVU/MTHI/MTLO (one cycle)
//   mode     in   4-bit operation code (0/7..15 = nothing)
//   op_a     in   rs operand (forwarded)
//   op_b     in   rt operand (forwarded)
//   abort    in   flush in-flight operation (MULDIV_ABORT_EN only)
//   busy     out  operation in flight (registered)
//   hi       out  architectural HI (registered)
//   lo       out  architectural LO (registered)

module muldiv_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  mode,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
`ifdef MULDIV_ABORT_EN
    input  logic        abort,
`endif
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MODE_MULT  = 4'd1;
    localparam logic [3:0] MODE_MULTU = 4'd2;
    localparam logic [3:0] MODE_DIV   = 4'd3;
    localparam logic [3:0] MODE_DIVU  = 4'd4;
    localparam logic [3:0] MODE_MTHI  = 4'd5;
    localparam logic [3:0] MODE_MTLO  = 4'd6;

    localparam logic [3:0] MUL_LIMIT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LIMIT = 4'(DIV_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  counter;
    logic [31:0] pending_hi;
    logic [31:0] pending_lo;
    logic        pending_wr;   // cleared for divide-by-zero: commit leaves HI/LO alone

    logic abort_req;
`ifdef MULDIV_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Result computation from the live operands; only sampled at start.
    // ------------------------------------------------------------------
    logic        is_signed_mul;
    logic        is_signed_div;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] safe_b;
    logic [31:0] uquot;
    logic [31:0] urem;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic        div_by_zero;

    always_comb begin
        is_signed_mul = (mode == MODE_MULT);
        is_signed_div = (mode == MODE_DIV);

        // Sign- or zero-extend to 64 bits; the low 64 bits of the product
        // are then correct for both signed and unsigned multiply.
        ext_a   = {{32{is_signed_mul & op_a[31]}}, op_a};
        ext_b   = {{32{is_signed_mul & op_b[31]}}, op_b};
        product = ext_a * ext_b;

        // Signed divide is done on magnitudes, then signs are restored:
        // quotient truncates toward zero, remainder follows the dividend.
        abs_a       = (is_signed_div && op_a[31]) ? (32'd0 - op_a) : op_a;
        abs_b       = (is_signed_div && op_b[31]) ? (32'd0 - op_b) : op_b;
        div_by_zero = (op_b == '0);
        safe_b      = div_by_zero ? 32'd1 : abs_b;
        uquot       = abs_a / safe_b;
        urem        = abs_a % safe_b;

        if (is_signed_div) begin
            div_q = (op_a[31] ^ op_b[31]) ? (32'd0 - uquot) : uquot;
            div_r = op_a[31] ? (32'd0 - urem) : urem;
            // Most-negative / -1 overflow is pinned explicitly.
            if (op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF) begin
                div_q = 32'h8000_0000;
                div_r = '0;
            end
        end else begin
            div_q = uquot;
            div_r = urem;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: single registered FSM, all outputs registered.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            counter    <= '0;
            busy       <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            pending_hi <= '0;
            pending_lo <= '0;
            pending_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort_req) begin
                        case (mode)
                            MODE_MULT, MODE_MULTU: begin
                                state      <= MUL;
                                counter    <= 4'd1;
                                busy       <= 1'b1;
                                pending_hi <= product[63:32];
                                pending_lo <= product[31:0];
                                pending_wr <= 1'b1;
                            end
                            MODE_DIV, MODE_DIVU: begin
                                state      <= DIV;
                                counter    <= 4'd1;
                                busy       <= 1'b1;
                                pending_hi <= div_r;
                                pending_lo <= div_q;
                                pending_wr <= !div_by_zero;
                            end
                            MODE_MTHI: hi <= op_a;
                            MODE_MTLO: lo <= op_a;
                            default: ;
                        endcase
                    end
                end

                MUL, DIV: begin
                    // start is ignored here; abort wins over a same-cycle commit.
                    if (abort_req) begin
                        state   <= IDLE;
                        counter <= '0;
                        busy    <= 1'b0;
                    end else if (counter == ((state == MUL) ? MUL_LIMIT : DIV_LIMIT)) begin
                        state   <= IDLE;
                        counter <= '0;
                        busy    <= 1'b0;
                        if (pending_wr) begin
                            hi <= pending_hi;
                            lo <= pending_lo;
                        end
                    end else begin
                        counter <= counter + 4'd1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    counter <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
